blackjack_button_pulser: RTL and testbench

BLACKJACK_BUTTON_PULSER -- requirements
Module: blackjack_button_pulser

---
 rtl/blackjack_button_pulser.sv | 172 +++++++++++++++++
 tb/tb_blackjack_button_pulser.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_button_pulser.sv
// Blackjack front-panel button conditioner: synchronizes and debounces the
// deal/hit/stand pushbuttons, latches one pending request per press, and
// arbitrates them into single-cycle active-low commands separated by a
// lockout window.
module blackjack_button_pulser #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LOCKOUT_CYCLES  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic key_deal_n,
    input  logic key_hit_n,
    input  logic key_stand_n,
    output logic deal,
    output logic hit,
    output logic stand,
    output logic busy
);

    localparam int unsigned NKEYS   = 3;
    localparam int unsigned CW      = 16;
    localparam int unsigned K_DEAL  = 0;
    localparam int unsigned K_HIT   = 1;
    localparam int unsigned K_STAND = 2;

    // Counter value on whose next mismatching cycle the threshold is reached
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    logic [NKEYS-1:0] keys_n;
    logic [NKEYS-1:0] sync1;
    logic [NKEYS-1:0] sync2;
    logic [NKEYS-1:0] deb;
    logic [NKEYS-1:0] deb_d;
    logic [NKEYS-1:0] fall;
    logic [NKEYS-1:0] pend;
    logic [NKEYS-1:0] clr;
    logic [NKEYS-1:0] pick;
    logic [CW-1:0]    cnt [NKEYS];

    state_t           state;
    state_t           state_nxt;
    logic [NKEYS-1:0] grant;
    logic [NKEYS-1:0] grant_nxt;
    logic [CW-1:0]    lock_cnt;
    logic [CW-1:0]    lock_nxt;
    logic             deal_nxt;
    logic             hit_nxt;
    logic             stand_nxt;
    logic             busy_nxt;

    assign keys_n = {key_stand_n, key_hit_n, key_deal_n};

    // A press is the debounced level falling; releases are ignored
    assign fall = deb_d & ~deb;

    // Per-key synchronizer, debouncer and pending latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_d <= '1;
            pend  <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= keys_n;
            sync2 <= sync1;
            deb_d <= deb;
            // A new press wins over a same-cycle grant clear
            pend  <= (pend & ~clr) | fall;
            for (int i = 0; i < NKEYS; i++) begin
                if (sync2[i] != deb[i]) begin
                    // Toggling on reaching the threshold keeps the counter from
                    // ever exceeding it
                    if (cnt[i] == DEB_LAST) begin
                        deb[i] <= ~deb[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Arbiter state and registered command outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            lock_cnt <= '0;
            deal     <= 1'b1;
            hit      <= 1'b1;
            stand    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            lock_cnt <= lock_nxt;
            deal     <= deal_nxt;
            hit      <= hit_nxt;
            stand    <= stand_nxt;
            busy     <= busy_nxt;
        end
    end

    // Arbiter next state, grant selection and output decode
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        lock_nxt  = lock_cnt;
        clr       = '0;
        pick      = '0;

        if (pend[K_DEAL]) begin
            pick[K_DEAL] = 1'b1;
        end else if (pend[K_STAND]) begin
            pick[K_STAND] = 1'b1;
        end else if (pend[K_HIT]) begin
            pick[K_HIT] = 1'b1;
        end

        case (state)
            IDLE: begin
                if (|pend) begin
                    state_nxt = PULSE;
                    grant_nxt = pick;
                    clr       = pick;
                end
            end
            PULSE: begin
                state_nxt = LOCKOUT;
                lock_nxt  = '0;
            end
            LOCKOUT: begin
                // End of lockout is the IDLE re-entry point; a waiting request
                // is granted there without spending a separate idle cycle
                if (lock_cnt == LOCK_LAST) begin
                    if (|pend) begin
                        state_nxt = PULSE;
                        grant_nxt = pick;
                        clr       = pick;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    lock_nxt = lock_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        deal_nxt  = ~((state_nxt == PULSE) & grant_nxt[K_DEAL]);
        hit_nxt   = ~((state_nxt == PULSE) & grant_nxt[K_HIT]);
        stand_nxt = ~((state_nxt == PULSE) & grant_nxt[K_STAND]);
        busy_nxt  = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_blackjack_button_pulser.sv
// Directed bench for blackjack_button_pulser with DEBOUNCE_CYCLES=4 and
// LOCKOUT_CYCLES=8; pulse times are hand-computed from the first clock edge
// that samples a key change (press latency 7, pulse spacing 9).
module tb_blackjack_button_pulser;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LOCK = 8;
    localparam int          LAT  = DEB + 3;
    localparam int          GAP  = LOCK + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_deal_n  = 1'b1;
    logic key_hit_n   = 1'b1;
    logic key_stand_n = 1'b1;
    logic deal;
    logic hit;
    logic stand;
    logic busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int n_deal, n_hit, n_stand, multi_low;
    int deal_at[4];
    int hit_at[4];
    int stand_at[4];

    blackjack_button_pulser #(
        .DEBOUNCE_CYCLES(DEB),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_deal_n (key_deal_n),
        .key_hit_n  (key_hit_n),
        .key_stand_n(key_stand_n),
        .deal       (deal),
        .hit        (hit),
        .stand      (stand),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_log();
        n_deal = 0; n_hit = 0; n_stand = 0; multi_low = 0;
        for (int i = 0; i < 4; i++) begin
            deal_at[i] = -1; hit_at[i] = -1; stand_at[i] = -1;
        end
    endtask

    // Advance n cycles, logging every low output cycle just after the edge
    task automatic run_cycles(input int n);
        int lows;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            lows = 0;
            if (deal === 1'b0) begin
                if (n_deal < 4) deal_at[n_deal] = cyc;
                n_deal++; lows++;
            end
            if (hit === 1'b0) begin
                if (n_hit < 4) hit_at[n_hit] = cyc;
                n_hit++; lows++;
            end
            if (stand === 1'b0) begin
                if (n_stand < 4) stand_at[n_stand] = cyc;
                n_stand++; lows++;
            end
            if (lows > 1) multi_low++;
        end
    endtask

    task automatic test_reset();
        run_cycles(2);
        checks++; if (deal !== 1'b1)  begin errors++; $display("FAIL reset_deal: got %b expected 1", deal); end
        checks++; if (hit !== 1'b1)   begin errors++; $display("FAIL reset_hit: got %b expected 1", hit); end
        checks++; if (stand !== 1'b1) begin errors++; $display("FAIL reset_stand: got %b expected 1", stand); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        clear_log();
        run_cycles(5);
        checks++; if (busy !== 1'b0 || n_deal + n_hit + n_stand != 0) begin
            errors++; $display("FAIL idle_after_reset: busy %b pulses %0d expected 0/0", busy, n_deal + n_hit + n_stand);
        end
    endtask

    task automatic test_single_deal();
        int c;
        clear_log();
        c = cyc;
        key_deal_n = 1'b0;
        run_cycles(20);
        key_deal_n = 1'b1;
        run_cycles(30);
        checks++; if (n_deal != 1) begin errors++; $display("FAIL deal_count: got %0d expected 1", n_deal); end
        checks++; if (deal_at[0] != c + 1 + LAT) begin errors++; $display("FAIL deal_latency: got cycle %0d expected %0d", deal_at[0], c + 1 + LAT); end
        checks++; if (n_hit != 0 || n_stand != 0) begin errors++; $display("FAIL deal_others: got hit %0d stand %0d expected 0", n_hit, n_stand); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL deal_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_bounce();
        int c;
        clear_log();
        c = 0;
        for (int i = 0; i < 5; i++) begin
            key_hit_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            c = cyc;
            run_cycles(2);
        end
        run_cycles(28);
        key_hit_n = 1'b1;
        run_cycles(30);
        checks++; if (n_hit != 1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", n_hit); end
        checks++; if (hit_at[0] != c + 1 + LAT) begin errors++; $display("FAIL bounce_latency: got cycle %0d expected %0d", hit_at[0], c + 1 + LAT); end
    endtask

    task automatic test_simultaneous();
        int c;
        int busy_bad;
        clear_log();
        busy_bad = 0;
        c = cyc;
        key_deal_n  = 1'b0;
        key_stand_n = 1'b0;
        for (int k = 0; k < 30; k++) begin
            run_cycles(1);
            if (cyc >= c + 1 + LAT && cyc <= c + 1 + LAT + GAP && busy !== 1'b1) busy_bad++;
        end
        key_deal_n  = 1'b1;
        key_stand_n = 1'b1;
        run_cycles(30);
        checks++; if (n_deal != 1 || deal_at[0] != c + 1 + LAT) begin errors++; $display("FAIL simul_deal: got %0d pulses at %0d expected 1 at %0d", n_deal, deal_at[0], c + 1 + LAT); end
        checks++; if (n_stand != 1 || stand_at[0] != c + 1 + LAT + GAP) begin errors++; $display("FAIL simul_stand: got %0d pulses at %0d expected 1 at %0d", n_stand, stand_at[0], c + 1 + LAT + GAP); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL simul_busy: got %0d low cycles expected 0", busy_bad); end
        checks++; if (multi_low != 0) begin errors++; $display("FAIL simul_onehot: got %0d overlap cycles expected 0", multi_low); end
    endtask

    task automatic test_priority();
        int c;
        clear_log();
        c = cyc;
        key_deal_n = 1'b0; key_hit_n = 1'b0; key_stand_n = 1'b0;
        run_cycles(40);
        key_deal_n = 1'b1; key_hit_n = 1'b1; key_stand_n = 1'b1;
        run_cycles(40);
        checks++; if (deal_at[0] != c + 1 + LAT) begin errors++; $display("FAIL prio_deal: got %0d expected %0d", deal_at[0], c + 1 + LAT); end
        checks++; if (stand_at[0] != c + 1 + LAT + GAP) begin errors++; $display("FAIL prio_stand: got %0d expected %0d", stand_at[0], c + 1 + LAT + GAP); end
        checks++; if (hit_at[0] != c + 1 + LAT + 2 * GAP) begin errors++; $display("FAIL prio_hit: got %0d expected %0d", hit_at[0], c + 1 + LAT + 2 * GAP); end
        checks++; if (n_deal + n_hit + n_stand != 3 || multi_low != 0) begin errors++; $display("FAIL prio_total: got %0d pulses %0d overlaps expected 3/0", n_deal + n_hit + n_stand, multi_low); end
    endtask

    task automatic test_back_to_back();
        int c;
        clear_log();
        c = cyc;
        key_hit_n = 1'b0;
        run_cycles(4);
        key_hit_n = 1'b1;
        run_cycles(5);
        key_hit_n = 1'b0;
        run_cycles(30);
        key_hit_n = 1'b1;
        run_cycles(30);
        checks++; if (n_hit != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", n_hit); end
        checks++; if (hit_at[0] != c + 1 + LAT) begin errors++; $display("FAIL b2b_first: got %0d expected %0d", hit_at[0], c + 1 + LAT); end
        checks++; if (hit_at[1] != c + 1 + LAT + GAP) begin errors++; $display("FAIL b2b_second: got %0d expected %0d", hit_at[1], c + 1 + LAT + GAP); end
    endtask

    task automatic test_glitch();
        int c;
        clear_log();
        key_stand_n = 1'b0;
        run_cycles(DEB - 1);
        key_stand_n = 1'b1;
        run_cycles(30);
        checks++; if (n_stand != 0 || busy !== 1'b0) begin errors++; $display("FAIL glitch_short: got %0d pulses busy %b expected 0/0", n_stand, busy); end
        // Exactly DEBOUNCE_CYCLES samples is the shortest accepted press
        clear_log();
        c = cyc;
        key_stand_n = 1'b0;
        run_cycles(DEB);
        key_stand_n = 1'b1;
        run_cycles(30);
        checks++; if (n_stand != 1 || stand_at[0] != c + 1 + LAT) begin errors++; $display("FAIL glitch_min: got %0d pulses at %0d expected 1 at %0d", n_stand, stand_at[0], c + 1 + LAT); end
    endtask

    task automatic test_reset_pulse();
        int c;
        int at;
        clear_log();
        c = cyc;
        at = -1;
        key_hit_n = 1'b0;
        for (int k = 0; k < 20 && at < 0; k++) begin
            run_cycles(1);
            if (hit === 1'b0) at = cyc;
        end
        checks++; if (at != c + 1 + LAT) begin errors++; $display("FAIL rstpulse_seen: got %0d expected %0d", at, c + 1 + LAT); end
        rst = 1'b1;
        #1;
        checks++; if (hit !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstpulse_async: got hit %b busy %b expected 1/0", hit, busy); end
        key_hit_n = 1'b1;
        run_cycles(3);
        checks++; if (hit !== 1'b1 || deal !== 1'b1 || stand !== 1'b1) begin errors++; $display("FAIL rstpulse_held: got %b%b%b expected 111", deal, hit, stand); end
        rst = 1'b0;
        clear_log();
        run_cycles(40);
        checks++; if (n_hit != 0 || busy !== 1'b0) begin errors++; $display("FAIL rstpulse_after: got %0d pulses busy %b expected 0/0", n_hit, busy); end
    endtask

    task automatic test_held_through_reset();
        int c;
        rst = 1'b1;
        key_deal_n = 1'b0;
        run_cycles(3);
        rst = 1'b0;
        clear_log();
        c = cyc;
        run_cycles(20);
        key_deal_n = 1'b1;
        run_cycles(30);
        checks++; if (n_deal != 1 || deal_at[0] != c + 1 + LAT) begin errors++; $display("FAIL held_reset: got %0d pulses at %0d expected 1 at %0d", n_deal, deal_at[0], c + 1 + LAT); end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_single_deal();
        test_bounce();
        test_simultaneous();
        test_priority();
        test_back_to_back();
        test_glitch();
        test_reset_pulse();
        test_held_through_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
